mbledhesi_serik: RTL and testbench
==================================

MBLEDHESI_SERIK -- requirements
Module: mbledhesi_serik

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 2..32.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RESET  input  1  reset, synchronous and active-high.
REQ-004 START  input  1  request a new addition; sampled on the rising edge.
REQ-005 A  input  WIDTH  first operand; sampled only when START is accepted.
REQ-006 B  input  WIDTH  second operand; sampled only when START is accepted.
REQ-007 CIN  input  1  carry-in to bit 0; sampled only when START is accepted.
REQ-008 SUM  output  WIDTH  registered result of the last completed addition.
REQ-009 COUT  output  1  registered carry-out of bit WIDTH-1 of the last completed addition.
REQ-010 OVF  output  1  registered two's-complement overflow of the last completed addition (carry into MSB XOR carry out of MSB).
REQ-011 BUSY  output  1  high while an addition is in progress.
REQ-012 DONE  output  1  single-cycle pulse marking that SUM/COUT/OVF were just updated.

Function
REQ-013 The block SHALL be a bit-serial adder: one full-adder cell (sum = a^b^c, carry = a&b | a&c | b&c) plus a carry flip-flop, processing one bit per clock, LSB first.
REQ-014 FSM states SHALL be IDLE, ADD, FIN; encoding is free.
REQ-015 IDLE: START=1 -> load A, B into operand shift registers, CIN into carry flop, bit counter := 0, go to ADD; START=0 -> stay.
REQ-016 ADD: each edge processes operand bit 0, shifts operands right by 1, shifts the sum bit into the result register at the MSB end, updates carry flop, increments counter.
REQ-017 ADD -> FIN on the edge that processes bit WIDTH-1; on that same edge SUM, COUT, OVF SHALL be loaded from the completed result.
REQ-018 FIN lasts exactly one cycle with DONE=1; then -> IDLE, unless START=1 in FIN, which SHALL be accepted exactly as in IDLE (go to ADD, new operands loaded).
REQ-019 Latency: START sampled at edge k -> DONE high in the cycle after edge k+WIDTH; throughput one addition per WIDTH+1 cycles when START is held high.
REQ-020 BUSY SHALL be 1 exactly in ADD; DONE SHALL be 1 exactly in FIN; never both.
REQ-021 START while in ADD SHALL be ignored (no reload, no queuing); A/B/CIN changes during ADD SHALL not affect the result.
REQ-022 SUM, COUT, OVF SHALL hold their values from REQ-017 until the next completion; partial results SHALL never appear on them.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH with full carry out: {COUT,SUM} = A + B + CIN.
REQ-024 OVF SHALL use the carry into bit WIDTH-1, captured in the cycle that processes bit WIDTH-2 -> WIDTH-1 transition.

Reset
REQ-025 RESET=1 at an edge SHALL force state IDLE and SUM=0, COUT=0, OVF=0, BUSY=0, DONE=0, counter/carry/shift registers to 0, overriding START.
REQ-026 RESET during ADD SHALL abort the operation with no DONE pulse and no output update; first START after RESET releases behaves per REQ-015.

Verification (WIDTH=8)
REQ-027 A=0x3C, B=0x25, CIN=0, START 1 cycle -> BUSY high 8 cycles, DONE pulse 1 cycle, SUM=0x61, COUT=0, OVF=0.
REQ-028 A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1, OVF=0; A=0x7F, B=0x01, CIN=0 -> SUM=0x80, COUT=0, OVF=1.
REQ-029 A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, COUT=1, OVF=0; A=0x80, B=0x80, CIN=0 -> SUM=0x00, COUT=1, OVF=1.
REQ-030 START pulsed again at cycle 3 of ADD with different A/B -> ignored; result matches first operands; exactly one DONE.
REQ-031 START held high continuously with A=0x01,B=0x01 then A=0x02,B=0x02 at the FIN cycle -> DONE every 9 cycles, SUM=0x02 then 0x04.
REQ-032 RESET asserted at cycle 4 of ADD -> all outputs 0 next cycle, no DONE; subsequent A=0x10, B=0x20 -> SUM=0x30.

Source files
------------

// File: rtl/mbledhesi_serik_if.sv
// Handshake and result bundle for the bit-serial adder.
//   master: drives start/a/b/cin, observes sum/cout/ovf/busy/done
//   slave : the adder side
interface mbledhesi_serik_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, a, b, cin,
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/mbledhesi_serik.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// one bit per clock. Result registers only update on the final bit, so
// partial sums never reach the outputs.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of mbledhesi_serik_if
//           start/a/b/cin in; sum/cout/ovf (registered), busy (ADD), done (FIN) out
module mbledhesi_serik #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    mbledhesi_serik_if.slave  bus
);
    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic fa_s;
    logic fa_c;
    logic last_bit;

    assign fa_s     = op_a[0] ^ op_b[0] ^ carry;
    assign fa_c     = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                // FIN accepts a new request exactly like IDLE, giving
                // back-to-back throughput of WIDTH+1 cycles.
                IDLE, FIN: begin
                    if (bus.start) begin
                        op_a  <= bus.a;
                        op_b  <= bus.b;
                        carry <= bus.cin;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    acc   <= {fa_s, acc[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here,
                        // captured while processing bit WIDTH-2.
                        sum_r  <= {fa_s, acc[WIDTH-1:1]};
                        cout_r <= fa_c;
                        ovf_r  <= carry ^ fa_c;
                        state  <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.busy = (state == ADD);
    assign bus.done = (state == FIN);
endmodule

// File: tb/tb_mbledhesi_serik.sv
module tb_mbledhesi_serik;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;

    mbledhesi_serik_if #(.WIDTH(W)) bus ();

    mbledhesi_serik #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, signed overflow from operand/result signs.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, output logic [W-1:0] s,
                         output logic co, output logic ov);
        int unsigned full;
        full = int'(ta) + int'(tb) + int'(tc);
        s    = full[W-1:0];
        co   = full[W];
        ov   = (ta[W-1] == tb[W-1]) && (s[W-1] != ta[W-1]);
    endtask

    // One addition; restart_at >= 0 pulses START with junk operands at
    // that ADD cycle. Operand inputs are scrambled throughout ADD.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input int restart_at, input string tag);
        logic [W-1:0] es;
        logic         ec, eo;
        int           busy_n;
        bit           got;
        bit           held;
        model(ta, tb, tc, es, ec, eo);
        busy_n = 0;
        got    = 0;
        held   = 1;
        @(negedge clk);
        bus.start = 1'b1; bus.a = ta; bus.b = tb; bus.cin = tc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                got = 1;
                break;
            end
            if (bus.busy) busy_n++;
            if (bus.sum !== last_sum || bus.cout !== last_cout || bus.ovf !== last_ovf)
                held = 0;
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.cin = 1'($urandom);
            if (busy_n == restart_at) bus.start = 1'b1;
        end
        chk(32'(got), 1, {tag, "_done"});
        chk(busy_n, W, {tag, "_busy_cycles"});
        chk(32'(held), 1, {tag, "_hold"});
        chk(32'(bus.busy), 0, {tag, "_busy_in_fin"});
        chk(32'(bus.sum), 32'(es), {tag, "_sum"});
        chk(32'(bus.cout), 32'(ec), {tag, "_cout"});
        chk(32'(bus.ovf), 32'(eo), {tag, "_ovf"});
        last_sum = es; last_cout = ec; last_ovf = eo;
        @(negedge clk);
        chk(32'(bus.done), 0, {tag, "_done_pulse"});
    endtask

    initial begin
        logic [W-1:0] es;
        logic         ec, eo;
        int           dn, t0, t1;
        logic [W-1:0] s0, s1;

        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(negedge clk);
        chk({bus.sum, bus.cout, bus.ovf, bus.busy, bus.done}, 0, "reset_outputs");
        reset = 1'b0;
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        @(negedge clk);
        chk(32'(bus.busy), 0, "idle_busy");

        run_op(8'h3C, 8'h25, 1'b0, -1, "r027");
        run_op(8'hFF, 8'h01, 1'b0, -1, "r028a");
        run_op(8'h7F, 8'h01, 1'b0, -1, "r028b");
        run_op(8'hFF, 8'hFF, 1'b1, -1, "r029a");
        run_op(8'h80, 8'h80, 1'b0, -1, "r029b");

        for (int i = 0; i < 16; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), -1, $sformatf("rnd%0d", i));

        // START during ADD is ignored; no second DONE follows.
        run_op(8'h12, 8'h34, 1'b1, 3, "r030");
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        chk(dn, 0, "r030_no_extra");

        // START held high: DONE every W+1 cycles.
        dn = 0; t0 = 0; t1 = 0; s0 = '0; s1 = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (dn == 0) begin
                    t0 = i; s0 = bus.sum;
                    bus.a = 8'h02; bus.b = 8'h02;
                end else begin
                    t1 = i; s1 = bus.sum;
                    bus.start = 1'b0;
                end
                dn++;
                if (dn == 2) break;
            end
        end
        bus.start = 1'b0;
        chk(dn, 2, "r031_dones");
        model(8'h01, 8'h01, 1'b0, es, ec, eo);
        chk(32'(s0), 32'(es), "r031_sum0");
        model(8'h02, 8'h02, 1'b0, es, ec, eo);
        chk(32'(s1), 32'(es), "r031_sum1");
        chk(t1 - t0, W + 1, "r031_period");
        last_sum = es; last_cout = ec; last_ovf = eo;
        repeat (2) @(negedge clk);

        // Reset in the middle of ADD aborts with no DONE.
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk(32'(bus.busy), 1, "r032_busy_before");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk({bus.sum, bus.cout, bus.ovf, bus.busy, bus.done}, 0, "r032_cleared");
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk(dn, 0, "r032_no_done");
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        run_op(8'h10, 8'h20, 1'b0, -1, "r032_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
